mem_port_arbiter: RTL and testbench

- Shares one single-port 1024x32 word memory between N_REQ requesters.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Grants one transaction at a time in round-robin order, drives the memory port, and returns read data or a write acknowledge to the granted requester.
- Sits between the requester masters and the memory array.

---
 rtl/mem_ctrl_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 66 ++++++
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared constants and types for the memory port arbiter slice.
//   DATA_W  - default memory data width
//   DEPTH   - default number of memory words
//   AW      - memory word address width derived from DEPTH
//   state_e - arbiter FSM state encoding (IDLE, ISSUE, WAIT, RESP)
// ---------------------------------------------------------------------------
package mem_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 1024;
    localparam int AW     = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin grant selection for the memory port arbiter.
// Ports:
//   clk            - clock, rising edge
//   reset_n        - asynchronous active-low reset (pointer returns to 0)
//   req_valid_i    - per-requester request valid
//   enable_i       - arbitration allowed this cycle (owner FSM is idle)
//   grant_any_o    - some requester is granted this cycle
//   grant_onehot_o - one-hot grant vector (all zero when nothing granted)
//   grant_idx_o    - binary index of the granted requester
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N_REQ = 2,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req_valid_i,
    input  logic             enable_i,
    output logic             grant_any_o,
    output logic [N_REQ-1:0] grant_onehot_o,
    output logic [IW-1:0]    grant_idx_o
);

    logic [IW-1:0] rr_ptr_q, rr_ptr_d;

    // Scan upward from the round-robin pointer with wrap; the first valid
    // requester found wins, so the most recent winner has lowest priority.
    always_comb begin
        int  idx;
        logic found;
        idx            = 0;
        found          = 1'b0;
        grant_any_o    = 1'b0;
        grant_onehot_o = '0;
        grant_idx_o    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!found && enable_i && req_valid_i[IW'(idx)]) begin
                found                       = 1'b1;
                grant_any_o                 = 1'b1;
                grant_onehot_o[IW'(idx)]    = 1'b1;
                grant_idx_o                 = IW'(idx);
            end
        end
    end

    // The pointer only moves on an actual grant, landing just past the winner.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_any_o) begin
            rr_ptr_d = (grant_idx_o == IW'(N_REQ - 1)) ? '0 : grant_idx_o + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port word memory between N_REQ requesters, one
// transaction at a time, granted in round-robin order.
// Optional feature macro: MEM_ARB_ADDR_CHECK_EN
//   defined   - addresses >= DEPTH get no memory access and rsp_err=1
//   undefined - addresses are truncated to AW bits, rsp_err tied to 0
// Ports:
//   clk, reset_n                  - clock / asynchronous active-low reset
//   req_valid/req_ready           - per-requester request handshake
//   req_write/req_addr/req_wdata  - request fields (packed per requester)
//   rsp_valid/rsp_ready           - per-requester response handshake
//   rsp_data/rsp_err              - response payload (shared by all)
//   mem_address/mem_write_data    - memory port address / write data
//   mem_write_enable/read_enable  - one-cycle memory strobes
//   mem_read_data                 - memory read data, one cycle after strobe
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter  int N_REQ  = 2,
    parameter  int DATA_W = mem_ctrl_pkg::DATA_W,
    parameter  int DEPTH  = mem_ctrl_pkg::DEPTH,
    localparam int AW     = $clog2(DEPTH),
    localparam int IW     = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ-1:0]        req_write,
    input  logic [N_REQ*32-1:0]     req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        rsp_valid,
    input  logic [N_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_err,
    output logic [AW-1:0]           mem_address,
    output logic [DATA_W-1:0]       mem_write_data,
    output logic                    mem_write_enable,
    output logic                    mem_read_enable,
    input  logic [DATA_W-1:0]       mem_read_data
);

    import mem_ctrl_pkg::*;

    state_e            state_q, state_d;
    logic              write_q, write_d;
    logic [31:0]       addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [IW-1:0]     gnt_q, gnt_d;
    logic              grant_any;
    logic [N_REQ-1:0]  grant_onehot;
    logic [IW-1:0]     grant_idx;
    logic              addr_bad;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid_i    (req_valid),
        .enable_i       (state_q == IDLE),
        .grant_any_o    (grant_any),
        .grant_onehot_o (grant_onehot),
        .grant_idx_o    (grant_idx)
    );

    // Accept is combinational: the arbiter only grants while idle.
    assign req_ready = grant_onehot;
    assign rsp_data  = rsp_data_q;

`ifdef MEM_ARB_ADDR_CHECK_EN
    logic rsp_err_q, rsp_err_d;
    assign addr_bad = (addr_q >= 32'(DEPTH));
    assign rsp_err  = rsp_err_q;
`else
    logic unused_addr_hi;
    assign addr_bad       = 1'b0;
    assign rsp_err        = 1'b0;
    assign unused_addr_hi = ^addr_q[31:AW];
`endif

    // Next-state and output decode. Memory port outputs are only driven in
    // ISSUE so the port reads as all-zero whenever no access is happening.
    always_comb begin
        state_d          = state_q;
        write_d          = write_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        gnt_d            = gnt_q;
        rsp_data_d       = rsp_data_q;
`ifdef MEM_ARB_ADDR_CHECK_EN
        rsp_err_d        = rsp_err_q;
`endif
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        mem_address      = '0;
        mem_write_data   = '0;
        rsp_valid        = '0;
        unique case (state_q)
            IDLE: begin
                if (grant_any) begin
                    for (int i = 0; i < N_REQ; i++) begin
                        if (grant_onehot[i]) begin
                            write_d = req_write[i];
                            addr_d  = req_addr[32*i +: 32];
                            wdata_d = req_wdata[DATA_W*i +: DATA_W];
                        end
                    end
                    gnt_d   = grant_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                rsp_data_d = '0;
`ifdef MEM_ARB_ADDR_CHECK_EN
                rsp_err_d  = addr_bad;
`endif
                if (addr_bad) begin
                    state_d = RESP;
                end else if (write_q) begin
                    mem_write_enable = 1'b1;
                    mem_address      = addr_q[AW-1:0];
                    mem_write_data   = wdata_q;
                    state_d          = RESP;
                end else begin
                    mem_read_enable  = 1'b1;
                    mem_address      = addr_q[AW-1:0];
                    state_d          = WAIT;
                end
            end
            WAIT: begin
                rsp_data_d = mem_read_data;
                state_d    = RESP;
            end
            RESP: begin
                rsp_valid = N_REQ'(1) << gnt_q;
                if (rsp_ready[gnt_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and transaction registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            gnt_q      <= '0;
            rsp_data_q <= '0;
`ifdef MEM_ARB_ADDR_CHECK_EN
            rsp_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            gnt_q      <= gnt_d;
            rsp_data_q <= rsp_data_d;
`ifdef MEM_ARB_ADDR_CHECK_EN
            rsp_err_q  <= rsp_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with a behavioural memory model and a
// response scoreboard. Honours MEM_ARB_ADDR_CHECK_EN for the address test.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int N_REQ  = 2;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1024;
    localparam int AW     = 10;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [N_REQ-1:0]        req_valid, req_ready, req_write;
    logic [N_REQ*32-1:0]     req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        rsp_valid, rsp_ready;
    logic [DATA_W-1:0]       rsp_data, mem_write_data, mem_read_data;
    logic                    rsp_err, mem_write_enable, mem_read_enable;
    logic [AW-1:0]           mem_address;

    typedef struct {
        int          who;
        logic [31:0] data;
        logic        err;
    } expRsp_t;

    expRsp_t     expQ[$];
    expRsp_t     monItem;
    int          errors = 0;
    int          checks = 0;
    int          wrCount = 0;
    int          rdCount = 0;
    logic [31:0] memArray [0:DEPTH-1];

    mem_port_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .rsp_err          (rsp_err),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_read_data    (mem_read_data)
    );

    always #5 clk = ~clk;

    // Behavioural single-port memory with one-cycle read latency; it is
    // never reset so data written before a reset pulse survives it.
    always @(posedge clk) begin
        if (mem_write_enable) memArray[mem_address] <= mem_write_data;
        if (mem_read_enable)  mem_read_data <= memArray[mem_address];
    end

    // Strobe counters used to prove each access strobes exactly once.
    always @(posedge clk) begin
        if (mem_write_enable) wrCount <= wrCount + 1;
        if (mem_read_enable)  rdCount <= rdCount + 1;
    end

    // Absolute safety net so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [N_REQ-1:0] onehot(input int i);
        return N_REQ'(1) << i;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        checkOutput({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
        checkOutput({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
        checkOutput({tag, "_mem_strobes"}, 64'({mem_write_enable, mem_read_enable}), 64'd0);
        checkOutput({tag, "_mem_address"}, 64'(mem_address), 64'd0);
        checkOutput({tag, "_mem_wdata"}, 64'(mem_write_data), 64'd0);
    endtask

    // Scoreboard consumer: pops one expectation per response handshake.
    task automatic monitorLoop();
        forever begin
            @(negedge clk);
            if (reset_n && ((rsp_valid & rsp_ready) != '0)) begin
                if (expQ.size() == 0) begin
                    checkOutput("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    monItem = expQ.pop_front();
                    checkOutput("rsp_who", 64'(rsp_valid), 64'(onehot(monItem.who)));
                    checkOutput("rsp_data", 64'(rsp_data), 64'(monItem.data));
                    checkOutput("rsp_err", 64'(rsp_err), 64'(monItem.err));
                end
            end
        end
    endtask

    task automatic applyStimulus(input int r, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge clk);
        #1;
        req_write[r]          = wr;
        req_addr[32*r +: 32]  = addr;
        req_wdata[32*r +: 32] = wdata;
        req_valid[r]          = 1'b1;
    endtask

    task automatic waitAccept(input int r, input logic [31:0] expData, input logic expErr);
        int n   = 0;
        bit got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk);
            n++;
            if (req_ready[r]) got = 1'b1;
        end
        checkOutput("accept_seen", 64'(got), 64'd1);
        @(posedge clk);
        #1;
        req_valid[r] = 1'b0;
        if (got) expQ.push_back('{who: r, data: expData, err: expErr});
    endtask

    task automatic waitRsp(input int r, input logic [1:0] expStrobe, input logic [31:0] addr,
                           input logic [31:0] wdata, input int expLat);
        int lat = 0;
        bit got = 1'b0;
        while (!got && lat < 50) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                checkOutput("strobe", 64'({mem_write_enable, mem_read_enable}), 64'(expStrobe));
                if (expStrobe != 2'b00) checkOutput("mem_address", 64'(mem_address), 64'(addr[AW-1:0]));
                if (expStrobe == 2'b10) checkOutput("mem_write_data", 64'(mem_write_data), 64'(wdata));
            end
            if (rsp_valid[r]) got = 1'b1;
        end
        checkOutput("rsp_latency", 64'(lat), 64'(expLat));
    endtask

    task automatic doTxn(input int r, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] expData, input logic expErr, input logic [1:0] expStrobe,
                         input int expLat);
        applyStimulus(r, wr, addr, wdata);
        waitAccept(r, expData, expErr);
        waitRsp(r, expStrobe, addr, wdata, expLat);
    endtask

    // Main directed sequence.
    initial begin
        int wr0, rd0, n, grants;
        bit got;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = '1;
        reset_n   = 1'b0;
        fork
            monitorLoop();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Idle: nothing requested, nothing moves.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("idle_quiet", 64'({mem_write_enable, mem_read_enable, req_ready, rsp_valid}), 64'd0);
        end

        // Single write then read-back from requester 0.
        wr0 = wrCount;
        rd0 = rdCount;
        doTxn(0, 1'b1, 32'd5, 32'hDEADBEEF, 32'h0, 1'b0, 2'b10, 2);
        doTxn(0, 1'b0, 32'd5, 32'h0, 32'hDEADBEEF, 1'b0, 2'b01, 3);
        checkOutput("write_pulses", 64'(wrCount - wr0), 64'd1);
        checkOutput("read_pulses", 64'(rdCount - rd0), 64'd1);

        // Response backpressure on requester 1 while requester 0 waits.
        doTxn(1, 1'b1, 32'd3, 32'h12345678, 32'h0, 1'b0, 2'b10, 2);
        applyStimulus(1, 1'b0, 32'd3, 32'h0);
        rsp_ready[1] = 1'b0;
        waitAccept(1, 32'h12345678, 1'b0);
        applyStimulus(0, 1'b1, 32'd20, 32'hA5A5A5A5);
        n   = 0;
        got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk);
            n++;
            if (rsp_valid[1]) got = 1'b1;
        end
        checkOutput("bp_rsp_seen", 64'(got), 64'd1);
        for (int h = 0; h < 5; h++) begin
            if (h > 0) @(negedge clk);
            checkOutput("bp_rsp_valid", 64'(rsp_valid), 64'(2'b10));
            checkOutput("bp_rsp_data", 64'(rsp_data), 64'h12345678);
            checkOutput("bp_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk);
        #1 rsp_ready[1] = 1'b1;
        waitAccept(0, 32'h0, 1'b0);
        waitRsp(0, 2'b10, 32'd20, 32'hA5A5A5A5, 2);

        // Out-of-range address handling.
        doTxn(0, 1'b1, 32'd0, 32'h00001111, 32'h0, 1'b0, 2'b10, 2);
`ifdef MEM_ARB_ADDR_CHECK_EN
        doTxn(1, 1'b1, 32'd1024, 32'hBAD00001, 32'h0, 1'b1, 2'b00, 2);
        doTxn(0, 1'b0, 32'd0, 32'h0, 32'h00001111, 1'b0, 2'b01, 3);
`else
        doTxn(1, 1'b1, 32'd1024, 32'hBAD00001, 32'h0, 1'b0, 2'b10, 2);
        doTxn(0, 1'b0, 32'd0, 32'h0, 32'hBAD00001, 1'b0, 2'b01, 3);
`endif

        // Reset pulsed during WAIT of a read by requester 0 (pointer now 1).
        doTxn(0, 1'b1, 32'd9, 32'h99990009, 32'h0, 1'b0, 2'b10, 2);
        applyStimulus(0, 1'b0, 32'd9, 32'h0);
        waitAccept(0, 32'h99990009, 1'b0);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1 checkAllZero("midreset");
        expQ.delete();
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Contention straight out of reset: grants must start at 0 and alternate.
        req_write = 2'b11;
        req_addr  = {32'd31, 32'd30};
        req_wdata = {32'h00000031, 32'h00000030};
        req_valid = 2'b11;
        grants    = 0;
        n         = 0;
        while (grants < 4 && n < 60) begin
            @(negedge clk);
            n++;
            if (req_ready != '0) begin
                checkOutput("contention_grant", 64'(req_ready), 64'(onehot(grants % 2)));
                expQ.push_back('{who: grants % 2, data: 32'h0, err: 1'b0});
                grants++;
            end
        end
        checkOutput("contention_grants", 64'(grants), 64'd4);
        @(posedge clk);
        #1 req_valid = '0;
        n = 0;
        while (expQ.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end

        // Write strobed before the reset must still be readable.
        doTxn(1, 1'b0, 32'd9, 32'h0, 32'h99990009, 1'b0, 2'b01, 3);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
